// File: rtl/linebuf_rd_ctrl.sv
// linebuf_rd_ctrl: read sequencer for the paged line RAM with line repeat and underrun detection.
// Optional LINEBUF_RD_BLANK_EN: an underrun emits a line of zero pixels instead of nothing. Rev 1.0
`default_nettype none

module linebuf_rd_ctrl #(
  parameter int num_of_pages = 2,
  parameter int pagesize     = 1024,
  parameter int data_width   = 32,
  parameter int max_repeat   = 2
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic                                line_done,
  input  logic [$clog2(num_of_pages)-1:0]     line_page,
  input  logic [$clog2(pagesize):0]           line_len,
  input  logic                                line_start,
  output logic                                rden,
  output logic [$clog2(num_of_pages)-1:0]     rdpage,
  output logic [$clog2(pagesize)-1:0]         rdaddr,
  input  logic [data_width-1:0]               rddata,
  output logic [data_width-1:0]               pix_data,
  output logic                                pix_valid,
  output logic                                busy,
  output logic                                underrun,
  output logic                                start_miss
);

  localparam int PAGE_W = $clog2(num_of_pages);
  localparam int ADDR_W = $clog2(pagesize);
  localparam int LEN_W  = ADDR_W + 1;
  localparam logic [3:0]       REP_MAX  = 4'(max_repeat);
  localparam logic [LEN_W-1:0] PAGE_LEN = LEN_W'(pagesize);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    BLANK = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [PAGE_W-1:0]     r_ready_page;
  logic [LEN_W-1:0]      r_ready_len;
  logic                  r_ready_valid;
  logic [PAGE_W-1:0]     r_cur_page;
  logic [LEN_W-1:0]      r_cur_len;
  logic                  r_cur_valid;
  logic [3:0]            r_rep_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_drain_cnt;
  logic                  r_vld_d1;
  logic                  r_vld_d2;
  logic [data_width-1:0] r_pix;
  logic                  r_underrun;
  logic                  r_start_miss;

  logic                  w_start_idle;
  logic                  w_take_new;
  logic                  w_repeat;
  logic                  w_under;
  logic [LEN_W-1:0]      w_burst_len;
  logic                  w_last;
  logic                  w_rden;
  logic                  w_busy;

  // Start decisions use the pending register as it stood before any same-cycle line_done.
  assign w_start_idle = line_start && (r_state == IDLE);
  assign w_take_new   = w_start_idle && r_ready_valid;
  assign w_repeat     = w_start_idle && !r_ready_valid && r_cur_valid && (r_rep_cnt < REP_MAX);
  assign w_under      = w_start_idle && !w_take_new && !w_repeat;
  assign w_burst_len  = w_take_new ? r_ready_len : r_cur_len;
  assign w_last       = ({1'b0, r_addr} == (r_cur_len - LEN_W'(1)));

`ifdef LINEBUF_RD_BLANK_EN
  logic [LEN_W-1:0] r_blank_cnt;
  logic [LEN_W-1:0] r_blank_len;
  logic [LEN_W-1:0] w_blank_len;

  assign w_blank_len = r_cur_valid ? r_cur_len : PAGE_LEN;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_rden     = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_take_new || w_repeat) begin
          w_state_nx = (w_burst_len == '0) ? DRAIN : READ;
        end
`ifdef LINEBUF_RD_BLANK_EN
        else if (w_under && (w_blank_len != '0)) begin
          w_state_nx = BLANK;
        end
`endif
      end
      READ: begin
        w_rden = 1'b1;
        w_busy = 1'b1;
        if (w_last) w_state_nx = DRAIN;
      end
      DRAIN: begin
        w_busy = 1'b1;
        if (r_drain_cnt) w_state_nx = IDLE;
      end
      BLANK: begin
`ifdef LINEBUF_RD_BLANK_EN
        w_busy = 1'b1;
        if (r_blank_cnt == (r_blank_len - LEN_W'(1))) w_state_nx = IDLE;
`else
        w_state_nx = IDLE;
`endif
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= IDLE;
      r_ready_page  <= '0;
      r_ready_len   <= '0;
      r_ready_valid <= 1'b0;
      r_cur_page    <= '0;
      r_cur_len     <= '0;
      r_cur_valid   <= 1'b0;
      r_rep_cnt     <= '0;
      r_addr        <= '0;
      r_drain_cnt   <= 1'b0;
      r_vld_d1      <= 1'b0;
      r_vld_d2      <= 1'b0;
      r_pix         <= '0;
      r_underrun    <= 1'b0;
      r_start_miss  <= 1'b0;
    end else begin
      r_state <= w_state_nx;

      if (line_done) begin
        r_ready_page <= line_page;
        r_ready_len  <= line_len;
      end
      if (line_done) begin
        r_ready_valid <= 1'b1;
      end else if (w_take_new) begin
        r_ready_valid <= 1'b0;
      end

      if (w_take_new) begin
        r_cur_page  <= r_ready_page;
        r_cur_len   <= r_ready_len;
        r_cur_valid <= 1'b1;
        r_rep_cnt   <= 4'd1;
      end else if (w_repeat) begin
        r_rep_cnt <= r_rep_cnt + 4'd1;
      end

      if ((r_state == READ) && !w_last) begin
        r_addr <= r_addr + ADDR_W'(1);
      end else begin
        r_addr <= '0;
      end

      r_drain_cnt <= (r_state == DRAIN) ? !r_drain_cnt : 1'b0;

      // Two stages: one for the RAM's read latency, one for the pix_data register.
      r_vld_d1 <= w_rden;
      r_vld_d2 <= r_vld_d1;
      if (r_vld_d1) r_pix <= rddata;

      r_underrun   <= w_under;
      r_start_miss <= r_start_miss | (line_start && (r_state != IDLE));
    end
  end

`ifdef LINEBUF_RD_BLANK_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_blank_cnt <= '0;
      r_blank_len <= '0;
    end else if (r_state == IDLE) begin
      r_blank_cnt <= '0;
      r_blank_len <= w_blank_len;
    end else if (r_state == BLANK) begin
      r_blank_cnt <= r_blank_cnt + LEN_W'(1);
    end
  end

  assign pix_valid = r_vld_d2 || (r_state == BLANK);
  assign pix_data  = (r_state == BLANK) ? '0 : r_pix;
`else
  assign pix_valid = r_vld_d2;
  assign pix_data  = r_pix;
`endif

  assign rden       = w_rden;
  assign rdpage     = r_cur_page;
  assign rdaddr     = r_addr;
  assign busy       = w_busy;
  assign underrun   = r_underrun;
  assign start_miss = r_start_miss;

endmodule

`default_nettype wire

// File: tb/tb_linebuf_rd_ctrl.sv
// Directed bench for linebuf_rd_ctrl: behavioural 1-cycle-latency RAM and hand-computed expectations.
`default_nettype none
`timescale 1ns/1ps

module tb_linebuf_rd_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        line_done = 1'b0;
  logic [0:0]  line_page = '0;
  logic [10:0] line_len = '0;
  logic        line_start = 1'b0;
  logic        rden;
  logic [0:0]  rdpage;
  logic [9:0]  rdaddr;
  logic [31:0] rddata = '0;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        busy;
  logic        underrun;
  logic        start_miss;

  linebuf_rd_ctrl dut (
    .CLK(CLK), .nRST(nRST), .line_done(line_done), .line_page(line_page),
    .line_len(line_len), .line_start(line_start), .rden(rden), .rdpage(rdpage),
    .rdaddr(rdaddr), .rddata(rddata), .pix_data(pix_data), .pix_valid(pix_valid),
    .busy(busy), .underrun(underrun), .start_miss(start_miss)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [0:1][0:1023];
  always @(posedge CLK) if (rden) rddata <= mem[rdpage][rdaddr];

  function automatic logic [31:0] ram_word(input int p, input int a);
    return 32'hA000_0000 | (p << 12) | a;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          n_rden, first_rden, n_pix, first_pix, busy_n, last_busy, und_n, addr_bad, blank_or;
  logic [0:0]  pg;
  logic [31:0] pix_q[$];

  function automatic logic [31:0] pix_at(input int j);
    if (j < pix_q.size()) return pix_q[j];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int p, input int l);
    line_done = 1'b1;
    line_page = 1'(p);
    line_len  = 11'(l);
    tick();
    line_done = 1'b0;
  endtask

  task automatic pulse_start();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Cycle 0 is the first cycle after the start pulse was sampled.
  task automatic observe(input int ncyc, input int miss_at);
    n_rden = 0; first_rden = -1; n_pix = 0; first_pix = -1;
    busy_n = 0; last_busy = -1; und_n = 0; addr_bad = 0; blank_or = 0; pg = '0;
    pix_q.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (rden) begin
        if (first_rden < 0) first_rden = i;
        if (int'(rdaddr) != n_rden) addr_bad++;
        pg = rdpage;
        n_rden++;
      end
      if (pix_valid) begin
        if (first_pix < 0) first_pix = i;
        pix_q.push_back(pix_data);
        if (pix_data != 0) blank_or++;
        n_pix++;
      end
      if (busy) begin
        busy_n++;
        last_busy = i;
      end
      if (underrun) und_n++;
      if (i == miss_at) line_start = 1'b1;
      tick();
      line_start = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 1024; a++)
        mem[p][a] = ram_word(p, a);

    repeat (3) tick();
    check("rst_rden", 32'(rden), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_start_miss", 32'(start_miss), 0);
    check("rst_rdaddr", 32'(rdaddr), 0);
    check("rst_pix_data", pix_data, 0);
    nRST = 1'b1;
    tick();

    // No page ever written: underrun.
    pulse_start();
`ifdef LINEBUF_RD_BLANK_EN
    observe(1100, -1);
    check("nopage_pix", 32'(n_pix), 1024);
    check("nopage_zero", 32'(blank_or), 0);
`else
    observe(10, -1);
    check("nopage_pix", 32'(n_pix), 0);
`endif
    check("nopage_und", 32'(und_n), 1);
    check("nopage_rden", 32'(n_rden), 0);

    // Fresh page 1, 4 words.
    load(1, 4);
    pulse_start();
    observe(12, -1);
    check("l1_rden_n", 32'(n_rden), 4);
    check("l1_first_rden", 32'(first_rden), 0);
    check("l1_addr_seq", 32'(addr_bad), 0);
    check("l1_page", 32'(pg), 1);
    check("l1_pix_n", 32'(n_pix), 4);
    check("l1_first_pix", 32'(first_pix), 2);
    for (int j = 0; j < 4; j++) check($sformatf("l1_data%0d", j), pix_at(j), ram_word(1, j));
    check("l1_busy_n", 32'(busy_n), 6);
    check("l1_busy_last", 32'(last_busy), 5);
    check("l1_und", 32'(und_n), 0);

    // Second start without a new page: re-read allowed.
    pulse_start();
    observe(12, -1);
    check("rep_rden_n", 32'(n_rden), 4);
    check("rep_page", 32'(pg), 1);
    check("rep_pix_n", 32'(n_pix), 4);
    check("rep_data3", pix_at(3), ram_word(1, 3));
    check("rep_und", 32'(und_n), 0);

    // Third start: repeat budget exhausted.
    pulse_start();
    observe(12, -1);
    check("exh_und", 32'(und_n), 1);
    check("exh_rden", 32'(n_rden), 0);
`ifdef LINEBUF_RD_BLANK_EN
    check("exh_pix", 32'(n_pix), 4);
`else
    check("exh_pix", 32'(n_pix), 0);
`endif

    // Newest pending page wins.
    load(0, 8);
    load(1, 5);
    pulse_start();
    observe(15, -1);
    check("nw_rden_n", 32'(n_rden), 5);
    check("nw_page", 32'(pg), 1);
    check("nw_pix_n", 32'(n_pix), 5);
    check("nw_data4", pix_at(4), ram_word(1, 4));

    // Start during a burst is ignored and sticks start_miss.
    load(0, 6);
    pulse_start();
    observe(20, 2);
    check("miss_rden_n", 32'(n_rden), 6);
    check("miss_pix_n", 32'(n_pix), 6);
    check("miss_data0", pix_at(0), ram_word(0, 0));
    check("miss_flag", 32'(start_miss), 1);

    // Zero-length page: drain only.
    load(0, 0);
    pulse_start();
    observe(8, -1);
    check("z_rden", 32'(n_rden), 0);
    check("z_busy_n", 32'(busy_n), 2);
    check("z_pix", 32'(n_pix), 0);
    check("z_und", 32'(und_n), 0);
    check("z_miss_sticky", 32'(start_miss), 1);

    // Asynchronous reset in the middle of a 16-word burst.
    load(1, 16);
    pulse_start();
    repeat (4) tick();
    check("ar_pre_rden", 32'(rden), 1);
    check("ar_pre_pix", 32'(pix_valid), 1);
    #2 nRST = 1'b0;
    #1;
    check("ar_rden", 32'(rden), 0);
    check("ar_pix", 32'(pix_valid), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_miss", 32'(start_miss), 0);
    tick();
    nRST = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
